keypad_scan_sequencer: RTL and testbench



---
 rtl/keypad_pkg.sv | 32 +++
 rtl/keypad_scan_sequencer_sync2.sv | 31 +++
 rtl/keypad_scan_sequencer.sv | 140 ++++++++++++++
 tb/tb_keypad_scan_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad column-scan controller.
// Provides the controller state type, the {row,col} -> hex key map,
// default tick counts for a 12 MHz clock, and a one-cold encoder
// used for both column drive and expected row patterns.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    // 100 us column dwell and 20 ms debounce at 12 MHz.
    localparam int DEFAULT_SCAN_TICKS     = 1200;
    localparam int DEFAULT_DEBOUNCE_TICKS = 240000;

    // Indexed by {row, col}; element 15 is listed first.
    //   r0: 1 2 3 A   r1: 4 5 6 B   r2: 7 8 9 C   r3: E(*) 0 F(#) D
    localparam logic [15:0][3:0] KEY_MAP = {
        4'hD, 4'hF, 4'h0, 4'hE,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    // Active-low one-hot: bit idx low, all others high.
    function automatic logic [3:0] one_cold(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/keypad_scan_sequencer_sync2.sv
// Two-flop synchronizer for asynchronous inputs.
// Ports:
//   clk    - destination clock
//   reset  - asynchronous active-low reset; both stages go to all-ones
//   d      - asynchronous input bus
//   q      - synchronized output bus (two clk cycles of latency)
// All-ones reset matches idle pulled-up keypad rows, so nothing looks
// pressed while the pipeline refills after reset.
module sync2 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= '1;
            q    <= '1;
        end else begin
            // NOTE: non-blocking so each stage takes the previous stage's old value.
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scan_sequencer.sv
// Column-scan controller for a 4x4 active-low matrix keypad.
// Drives one column low at a time, samples synchronized rows, debounces
// press and release, and emits one key_valid strobe per physical press.
// Ports:
//   clk          - system clock (12 MHz)
//   reset        - asynchronous active-low reset
//   keypad_rows  - raw row pins, active-low, asynchronous to clk
//   keypad_cols  - column drive, one-hot active-low
//   key_code     - hex code of the last accepted key, held until the next
//   key_valid    - one-cycle strobe when a new key is accepted
//   key_held     - high while the accepted key is down (through release debounce)
module keypad_scan_sequencer
    import keypad_pkg::*;
#(
    parameter int SCAN_TICKS     = DEFAULT_SCAN_TICKS,
    parameter int DEBOUNCE_TICKS = DEFAULT_DEBOUNCE_TICKS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] keypad_rows,
    output logic [3:0] keypad_cols,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int MAX_TICKS = (SCAN_TICKS > DEBOUNCE_TICKS) ? SCAN_TICKS : DEBOUNCE_TICKS;
    localparam int CNT_W     = $clog2(MAX_TICKS);
    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_TICKS - 1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_TICKS - 1);

    logic [3:0]       rows_s;
    state_t           state;
    logic [1:0]       col;
    logic [1:0]       row;
    logic [CNT_W-1:0] cnt;
    logic             one_low;
    logic [1:0]       low_row;

    sync2 #(.WIDTH(4)) u_row_sync (
        .clk   (clk),
        .reset (reset),
        .d     (keypad_rows),
        .q     (rows_s)
    );

    // Accept only a single low row; ghosting or multi-key presses in one
    // column are skipped rather than guessed at.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        one_low = 1'b1;
        low_row = 2'd0;
        case (rows_s)
            4'b1110: low_row = 2'd0;
            4'b1101: low_row = 2'd1;
            4'b1011: low_row = 2'd2;
            4'b0111: low_row = 2'd3;
            default: one_low = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= SCAN;
            col         <= 2'd0;
            row         <= 2'd0;
            cnt         <= '0;
            keypad_cols <= 4'b1110;
            key_code    <= 4'h0;
            key_valid   <= 1'b0;
            key_held    <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            case (state)
                SCAN: begin
                    // Dwell lets the column settle and clears the sync latency.
                    if (cnt == SCAN_LAST) begin
                        cnt <= '0;
                        if (one_low) begin
                            row   <= low_row;
                            state <= DEBOUNCE;
                        end else begin
                            col         <= col + 2'd1;
                            keypad_cols <= one_cold(col + 2'd1);
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DEBOUNCE: begin
                    // Any deviation from the latched one-low pattern aborts
                    // and rescans the same column from a fresh dwell.
                    if (rows_s != one_cold(row)) begin
                        state <= SCAN;
                        cnt   <= '0;
                    end else if (cnt == DEB_LAST) begin
                        state     <= HELD;
                        cnt       <= '0;
                        key_valid <= 1'b1;
                        key_code  <= KEY_MAP[{row, col}];
                        key_held  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                HELD: begin
                    // Only the latched row matters; other rows in this
                    // column and all other columns are ignored.
                    if (rows_s[row]) begin
                        state <= RELEASE;
                        cnt   <= '0;
                    end
                end

                RELEASE: begin
                    if (!rows_s[row]) begin
                        state <= HELD;
                        cnt   <= '0;
                    end else if (cnt == DEB_LAST) begin
                        state       <= SCAN;
                        cnt         <= '0;
                        key_held    <= 1'b0;
                        col         <= col + 2'd1;
                        keypad_cols <= one_cold(col + 2'd1);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    state <= SCAN;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scan_sequencer.sv
// Directed self-checking bench for keypad_scan_sequencer.
// A small keypad model pulls a row low whenever a pressed key sits in a
// column the DUT is driving low; a bounce mask can force rows high.
module tb_keypad_scan_sequencer;

    localparam int SCAN_TICKS     = 4;
    localparam int DEBOUNCE_TICKS = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] keypad_rows;
    logic [3:0] keypad_cols;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [15:0] pressed;   // index {row, col}
    logic [3:0]  bounce;    // 1 forces that row pin high

    int   checks  = 0;
    int   errors  = 0;
    int   strobes = 0;
    int   doubles = 0;
    logic prev_valid = 1'b0;

    keypad_scan_sequencer #(
        .SCAN_TICKS     (SCAN_TICKS),
        .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .keypad_rows (keypad_rows),
        .keypad_cols (keypad_cols),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_held    (key_held)
    );

    always #5 clk = ~clk;

    always_comb begin
        keypad_rows = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && (keypad_cols[c] == 1'b0))
                    keypad_rows[r] = 1'b0;
        keypad_rows = keypad_rows | bounce;
    end

    // Counts strobes and back-to-back strobe cycles.
    always @(negedge clk) begin
        if (key_valid === 1'b1) strobes++;
        if (key_valid === 1'b1 && prev_valid === 1'b1) doubles++;
        prev_valid = key_valid;
    end

    function automatic logic [3:0] col_pins(input int c);
        case (c)
            0:       col_pins = 4'b1110;
            1:       col_pins = 4'b1101;
            2:       col_pins = 4'b1011;
            default: col_pins = 4'b0111;
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic wait_valid(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (key_valid === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic wait_released(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (key_held === 1'b0) seen = 1'b1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int         s0;
        bit         seen;
        logic [3:0] last_cols;
        int         changes;

        reset   = 1'b0;
        pressed = '0;
        bounce  = '0;
        tick(3);

        // 1: reset values, then free-running scan with no keys.
        check("rst_cols",  keypad_cols, 4'b1110);
        check("rst_code",  key_code,    4'h0);
        check("rst_valid", key_valid,   1'b0);
        check("rst_held",  key_held,    1'b0);
        reset = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("scan_cols",  keypad_cols, col_pins(((i + 1) / 4) % 4));
            check("scan_valid", key_valid,   1'b0);
        end

        // 2: clean press and release of '5'.
        s0 = strobes;
        pressed[5] = 1'b1;
        wait_valid(60, seen);
        check("k5_seen", seen,     1'b1);
        check("k5_code", key_code, 4'h5);
        check("k5_held", key_held, 1'b1);
        tick(1);
        check("k5_pulse_width", key_valid,   1'b0);
        check("k5_col_frozen",  keypad_cols, 4'b1101);
        tick(30);
        check("k5_still_held", key_held,     1'b1);
        check("k5_one_strobe", strobes - s0, 1);
        pressed[5] = 1'b0;
        tick(9);
        check("k5_release_early", key_held, 1'b1);
        tick(2);
        check("k5_release_done", key_held,    1'b0);
        check("k5_next_col",     keypad_cols, 4'b1011);
        check("k5_code_kept",    key_code,    4'h5);

        // 3: '#' with contact bounce, then stable.
        s0 = strobes;
        pressed[14] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bounce = (((i / 3) % 2) != 0) ? 4'b1000 : 4'b0000;
            tick(1);
        end
        bounce = 4'b0000;
        check("hash_bounce_quiet", strobes - s0, 0);
        wait_valid(60, seen);
        check("hash_seen", seen,     1'b1);
        check("hash_code", key_code, 4'hF);
        tick(10);
        check("hash_one_strobe", strobes - s0, 1);
        pressed[14] = 1'b0;
        wait_released(40, seen);
        check("hash_released", seen, 1'b1);

        // 4: two rows low in column 0 is rejected; scanning continues.
        s0 = strobes;
        pressed[0] = 1'b1;
        pressed[8] = 1'b1;
        last_cols = keypad_cols;
        changes   = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (keypad_cols !== last_cols) changes++;
            last_cols = keypad_cols;
        end
        check("multi_col_changes", changes,      10);
        check("multi_no_strobe",   strobes - s0, 0);
        check("multi_not_held",    key_held,     1'b0);
        check("multi_code_kept",   key_code,     4'hF);
        pressed = '0;
        tick(2);

        // 5: hold '5', other keys ignored, release glitch returns to HELD.
        s0 = strobes;
        pressed[5] = 1'b1;
        wait_valid(60, seen);
        check("hold5_seen", seen,     1'b1);
        check("hold5_code", key_code, 4'h5);
        pressed[3] = 1'b1;
        pressed[1] = 1'b1;
        tick(20);
        check("hold5_others_held", key_held,    1'b1);
        check("hold5_others_col",  keypad_cols, 4'b1101);
        pressed[1] = 1'b0;
        pressed[3] = 1'b0;
        tick(10);
        pressed[5] = 1'b0;
        tick(3);
        pressed[5] = 1'b1;
        tick(15);
        check("glitch_still_held", key_held,     1'b1);
        check("glitch_col",        keypad_cols,  4'b1101);
        check("glitch_one_strobe", strobes - s0, 1);
        check("no_double_pulse",   doubles,      0);
        pressed[5] = 1'b0;
        wait_released(40, seen);
        check("hold5_released", seen,        1'b1);
        check("hold5_next_col", keypad_cols, 4'b1011);

        // 6: reset while '9' is mid-debounce.
        s0 = strobes;
        pressed[10] = 1'b1;
        tick(9);
        check("k9_col_frozen", keypad_cols, 4'b1011);
        check("k9_not_held",   key_held,    1'b0);
        reset = 1'b0;
        #1;
        check("mid_rst_cols",  keypad_cols, 4'b1110);
        check("mid_rst_code",  key_code,    4'h0);
        check("mid_rst_valid", key_valid,   1'b0);
        check("mid_rst_held",  key_held,    1'b0);
        pressed = '0;
        tick(3);
        reset = 1'b1;
        check("k9_no_strobe", strobes - s0, 0);
        tick(3);
        check("restart_col0", keypad_cols, 4'b1110);
        tick(1);
        check("restart_col1", keypad_cols, 4'b1101);
        tick(20);
        check("k9_never_strobed", strobes - s0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
